// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory wait/timeout handling.
// Optional performance counter of front-end stall cycles is enabled with `define HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int REG_AW      = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rdE,
    input  logic              ld_E,
    input  logic              pc_src_E,
    input  logic              mem_req_M,
    input  logic              mem_ack,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              mem_err,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_t;

    localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [7:0] wcnt;
    logic       lw_stall;
    logic       mem_stall;

    // Register x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign lw_stall  = ld_E && (rdE != '0) && ((rs1D == rdE) || (rs2D == rdE));
    assign mem_stall = mem_req_M && !mem_ack && (state != MEM_ERR);

    // Every non-stalling cycle returns to IDLE, which covers ack, dropped request and the error cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= 8'd0;
        end else if (mem_stall) begin
            wcnt <= wcnt + 8'd1;
            if (wcnt == WCNT_LAST) begin
                state <= MEM_ERR;
            end else begin
                state <= MEM_WAIT;
            end
        end else begin
            wcnt  <= 8'd0;
            state <= IDLE;
        end
    end

    assign mem_err = (state == MEM_ERR);

    // A memory stall freezes the whole pipeline; branch and load-use responses wait until it releases.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall && !pc_src_E;
                StallD = lw_stall && !pc_src_E;
                FlushE = lw_stall || pc_src_E;
                FlushD = pc_src_E;
                FlushW = (state == MEM_ERR);
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (StallF && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule
